axis_fifo_csr: RTL and testbench

- Next-generation AXI-Stream buffer with an AXI-Lite control/status slave.
- Adds over the previous block:
  - a parametrised read side (AXI-Stream master) and tlast storage;
  - full AXI-Lite handshaking (independent AW/W, held B/R);
  - a programmable almost-full threshold, drop mode with a drop counter, a packet counter, and a maskable interrupt.
- Sits between a stream producer and a downstream consumer; software configures it and monitors it over AXI-Lite.

---
 rtl/axis_fifo_csr_if.sv | 46 ++++
 rtl/axis_fifo_csr.sv | 235 +++++++++++++++++++++++
 tb/tb_axis_fifo_csr.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_csr_if.sv
// Bus interfaces for axis_fifo_csr: an AXI-Lite slave port and an AXI-Stream link.
// The master modport is the side that drives the valid/payload signals.

interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface axi_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_fifo_csr.sv
// AXI-Stream FIFO (first-word fall-through, data + tlast) with an AXI-Lite
// control/status slave: flush, drop mode, almost-full threshold, drop and
// packet counters, and a maskable level interrupt.

module axis_fifo_csr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_RESET   = FIFO_DEPTH - 2
) (
  input  logic       ACLK,
  input  logic       ARESET,
  axi_lite_if.slave  s_axi,
  axi_stream_if.slave  s_axis,
  axi_stream_if.master m_axis,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_THRESH = 4'd2;
  localparam logic [3:0] REG_DROP   = 4'd3;
  localparam logic [3:0] REG_PKT    = 4'd4;
  localparam logic [3:0] REG_IRQ    = 4'd5;

  // ---------------------------------------------------------------- state
  logic                  rst_done_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  logic                  drop_mode_q, irq_en_q, flush_q;
  logic [15:0]           thresh_q;
  logic [31:0]           drop_cnt_q, pkt_cnt_q;
  logic [1:0]            irq_status_q;
  logic                  af_q, irq_q;

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------- FIFO status
  logic [PW-1:0] occ;
  logic [15:0]   occ16;
  logic          full, empty, almost_full;
  logic          s_hs, push, drop, pop;

  assign occ         = wr_ptr_q - rd_ptr_q;
  assign occ16       = 16'(occ);
  assign full        = (occ == PW'(FIFO_DEPTH));
  assign empty       = (occ == '0);
  assign almost_full = (occ16 >= thresh_q);

  // Readies stay low until the first edge after reset release.
  assign s_axis.tready = rst_done_q && !flush_q && (drop_mode_q || !full);
  assign m_axis.tvalid = !empty && !flush_q;
  assign {m_axis.tlast, m_axis.tdata} = mem_q[rd_ptr_q[AW-1:0]];

  assign s_hs = s_axis.tvalid && s_axis.tready;
  assign push = s_hs && !full;
  assign drop = s_hs && full;
  assign pop  = m_axis.tvalid && m_axis.tready;

  // ---------------------------------------------------------------- AXI-Lite write path
  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata_sel;
  logic [3:0]            wstrb_sel;
  logic [3:0]            widx;
  logic                  wr_ctrl, wr_thresh, wr_drop, wr_pkt, wr_irq;

  assign s_axi.awready = rst_done_q && !aw_held_q && !bvalid_q;
  assign s_axi.wready  = rst_done_q && !w_held_q && !bvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

  assign aw_hs     = s_axi.awvalid && s_axi.awready;
  assign w_hs      = s_axi.wvalid && s_axi.wready;
  assign commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign waddr     = aw_held_q ? awaddr_q : s_axi.awaddr;
  assign wdata_sel = w_held_q ? wdata_q : s_axi.wdata;
  assign wstrb_sel = w_held_q ? wstrb_q : s_axi.wstrb;
  assign widx      = waddr[5:2];

  assign wr_ctrl   = commit && (widx == REG_CTRL);
  assign wr_thresh = commit && (widx == REG_THRESH);
  assign wr_drop   = commit && (widx == REG_DROP);
  assign wr_pkt    = commit && (widx == REG_PKT);
  assign wr_irq    = commit && (widx == REG_IRQ);

  // Latch AW and W independently; issue B the cycle after both are present.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_done_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      rst_done_q <= 1'b1;
      if (aw_hs) awaddr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= (widx <= REG_IRQ) ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs) aw_held_q <= 1'b1;
        if (w_hs)  w_held_q  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- AXI-Lite read path
  logic        ar_hs;
  logic [31:0] rd_data_c;
  logic [1:0]  rd_resp_c;

  assign s_axi.arready = rst_done_q && !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign ar_hs         = s_axi.arvalid && s_axi.arready;

  // Register read mux; unmapped offsets return a marker with SLVERR.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_data_c = 32'hDEAD_BEEF;
    rd_resp_c = 2'b10;
    case (s_axi.araddr[5:2])
      REG_CTRL:   begin rd_data_c = {29'd0, irq_en_q, drop_mode_q, 1'b0}; rd_resp_c = 2'b00; end
      REG_STATUS: begin rd_data_c = {13'd0, almost_full, full, empty, occ16}; rd_resp_c = 2'b00; end
      REG_THRESH: begin rd_data_c = {16'd0, thresh_q}; rd_resp_c = 2'b00; end
      REG_DROP:   begin rd_data_c = drop_cnt_q; rd_resp_c = 2'b00; end
      REG_PKT:    begin rd_data_c = pkt_cnt_q; rd_resp_c = 2'b00; end
      REG_IRQ:    begin rd_data_c = {30'd0, irq_status_q}; rd_resp_c = 2'b00; end
      default:    ;
    endcase
  end

  // Capture read data on AR handshake and hold R until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_c;
      rresp_q  <= rd_resp_c;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- control / status registers
  // CTRL, THRESH, counters, sticky interrupt bits and the registered irq.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      drop_mode_q  <= 1'b0;
      irq_en_q     <= 1'b0;
      flush_q      <= 1'b0;
      thresh_q     <= 16'(AF_RESET);
      drop_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      irq_status_q <= '0;
      af_q         <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      flush_q <= wr_ctrl && wstrb_sel[0] && wdata_sel[0];
      if (wr_ctrl && wstrb_sel[0]) begin
        drop_mode_q <= wdata_sel[1];
        irq_en_q    <= wdata_sel[2];
      end
      if (wr_thresh && wstrb_sel[0]) thresh_q[7:0]  <= wdata_sel[7:0];
      if (wr_thresh && wstrb_sel[1]) thresh_q[15:8] <= wdata_sel[15:8];

      if (wr_drop)                           drop_cnt_q <= '0;
      else if (drop && (drop_cnt_q != '1))   drop_cnt_q <= drop_cnt_q + 32'd1;

      if (wr_pkt)                 pkt_cnt_q <= '0;
      else if (push && s_axis.tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;

      // A set event in the same cycle as its W1C wins.
      irq_status_q <= (irq_status_q & ~(wr_irq ? wdata_sel[1:0] : 2'b00))
                    | {drop, almost_full && !af_q};
      af_q  <= almost_full;
      irq_q <= irq_en_q && (|irq_status_q);
    end
  end

  assign irq = irq_q;

  // FIFO pointers; a flush pulse clears both at its end.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage write port.
  // NOTE: the data array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
  end

  // Address bits above [5:2] and unused data/strobe bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{waddr, s_axi.araddr, wdata_sel[31:16], wstrb_sel[3:2]};

endmodule

// File: tb/tb_axis_fifo_csr.sv
// Self-checking bench for axis_fifo_csr: register access, FIFO fill/drain,
// drop mode and interrupts, AXI-Lite channel ordering, flush and mid-write reset.

module tb_axis_fifo_csr;

  logic clk;
  logic rst;
  logic irq;

  axi_lite_if   #(.ADDR_WIDTH(32)) axil ();
  axi_stream_if #(.DATA_WIDTH(32)) sin ();
  axi_stream_if #(.DATA_WIDTH(32)) sout ();

  axis_fifo_csr #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16), .AF_RESET(14)
  ) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(axil), .s_axis(sin), .m_axis(sout), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected output beats {tlast, tdata}.
  logic [32:0] sb_q[$];

  logic [31:0] rd;
  logic [1:0]  rr;
  logic [1:0]  br;

  // ---------------------------------------------------------------- bus tasks
  // All tasks start and end 1 time unit after a rising edge.
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, b_done, aw_rdy, w_rdy;
    axil.awaddr = addr; axil.awvalid = 1'b1;
    axil.wdata  = data; axil.wstrb = strb; axil.wvalid = 1'b1;
    aw_done = 0; w_done = 0; b_done = 0; resp = 2'b11;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      aw_rdy = axil.awready; w_rdy = axil.wready;
      @(posedge clk); #1;
      if (aw_rdy && axil.awvalid) begin aw_done = 1; axil.awvalid = 1'b0; end
      if (w_rdy && axil.wvalid)   begin w_done = 1;  axil.wvalid  = 1'b0; end
    end
    axil.bready = 1'b1;
    for (int i = 0; i < 50 && !b_done; i++) begin
      if (axil.bvalid) begin resp = axil.bresp; b_done = 1; end
      @(posedge clk); #1;
    end
    axil.bready = 1'b0; axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    if (!(aw_done && w_done && b_done)) begin
      n_checks++; n_fail++;
      $display("FAIL axil_write_timeout addr=%h aw=%0b w=%0b b=%0b", addr, aw_done, w_done, b_done);
    end
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done, r_done, ar_rdy;
    axil.araddr = addr; axil.arvalid = 1'b1;
    ar_done = 0; r_done = 0; data = 32'hx; resp = 2'bxx;
    for (int i = 0; i < 50 && !ar_done; i++) begin
      ar_rdy = axil.arready;
      @(posedge clk); #1;
      if (ar_rdy) begin ar_done = 1; axil.arvalid = 1'b0; end
    end
    axil.rready = 1'b1;
    for (int i = 0; i < 50 && !r_done; i++) begin
      if (axil.rvalid) begin data = axil.rdata; resp = axil.rresp; r_done = 1; end
      @(posedge clk); #1;
    end
    axil.rready = 1'b0; axil.arvalid = 1'b0;
    if (!(ar_done && r_done)) begin
      n_checks++; n_fail++;
      $display("FAIL axil_read_timeout addr=%h", addr);
    end
  endtask

  task automatic push_beat(input logic [31:0] data, input logic last, output bit accepted);
    bit rdy;
    sin.tdata = data; sin.tlast = last; sin.tvalid = 1'b1; accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      rdy = sin.tready;
      @(posedge clk); #1;
      if (rdy) accepted = 1;
    end
    sin.tvalid = 1'b0; sin.tlast = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    axil.awaddr = '0; axil.awvalid = 0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 0;
    axil.bready = 0; axil.araddr = '0; axil.arvalid = 0; axil.rready = 0;
    sin.tdata = '0; sin.tvalid = 0; sin.tlast = 0; sout.tready = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid,
         sin.tready, sout.tvalid, irq} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000", {axil.awready, axil.wready,
               axil.arready, axil.bvalid, axil.rvalid, sin.tready, sout.tvalid, irq});
    end
    n_checks++;
    if (axil.rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00000000", axil.rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({axil.awready, axil.wready, axil.arready, sin.tready} !== 4'hF) begin
      n_fail++; $display("FAIL ready_after_reset: got %b want 1111",
                         {axil.awready, axil.wready, axil.arready, sin.tready});
    end
    axil_read(32'h04, rd, rr);
    n_checks++;
    if (rd !== 32'h0001_0000 || rr !== 2'b00) begin
      n_fail++; $display("FAIL status_reset: got %h/%b want 00010000/00", rd, rr);
    end
    axil_read(32'h08, rd, rr);
    n_checks++;
    if (rd !== 32'd14 || rr !== 2'b00) begin
      n_fail++; $display("FAIL thresh_reset: got %h/%b want 0000000e/00", rd, rr);
    end
    axil_read(32'h20, rd, rr);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || rr !== 2'b10) begin
      n_fail++; $display("FAIL unmapped_read: got %h/%b want deadbeef/10", rd, rr);
    end
    axil_write(32'h20, 32'h1234, 4'hF, br);
    n_checks++;
    if (br !== 2'b10) begin
      n_fail++; $display("FAIL unmapped_write_bresp: got %b want 10", br);
    end
    axil_write(32'h04, 32'hFFFF_FFFF, 4'hF, br);
    axil_read(32'h04, rd, rr);
    n_checks++;
    if (br !== 2'b00 || rd !== 32'h0001_0000) begin
      n_fail++; $display("FAIL status_ro_write: got bresp %b status %h want 00 00010000", br, rd);
    end
  endtask

  task automatic test_fill_drain();
    bit ok;
    logic [32:0] exp;
    sout.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_beat(32'h100 + i, (i == 7) || (i == 15), ok);
      if (ok) sb_q.push_back({((i == 7) || (i == 15)) ? 1'b1 : 1'b0, 32'h100 + i});
    end
    n_checks++;
    if (sin.tready !== 1'b0) begin
      n_fail++; $display("FAIL full_tready: got %b want 0", sin.tready);
    end
    axil_read(32'h04, rd, rr);
    n_checks++;
    if (rd !== 32'h0006_0010) begin
      n_fail++; $display("FAIL status_full: got %h want 00060010", rd);
    end
    axil_read(32'h10, rd, rr);
    n_checks++;
    if (rd !== 32'd2) begin
      n_fail++; $display("FAIL pkt_cnt: got %0d want 2", rd);
    end
    sout.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0;
      n_checks++;
      if (sout.tvalid !== 1'b1 || {sout.tlast, sout.tdata} !== exp) begin
        n_fail++; $display("FAIL drain_beat%0d: got v=%b %b/%h want v=1 %b/%h", i,
                           sout.tvalid, sout.tlast, sout.tdata, exp[32], exp[31:0]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sout.tvalid !== 1'b0) begin
      n_fail++; $display("FAIL drained_tvalid: got %b want 0", sout.tvalid);
    end
    sout.tready = 1'b0;
  endtask

  task automatic test_drop_irq();
    bit ok;
    int n_acc;
    logic [32:0] exp;
    axil_write(32'h00, 32'h2, 4'hF, br);
    axil_write(32'h14, 32'h3, 4'hF, br);
    axil_read(32'h14, rd, rr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL irq_status_w1c: got %h want 00000000", rd);
    end
    for (int i = 0; i < 16; i++) begin
      push_beat(32'h200 + i, 1'b0, ok);
      if (ok) sb_q.push_back({1'b0, 32'h200 + i});
    end
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push_beat(32'h2F0 + i, 1'b0, ok);
      if (ok) n_acc++;
    end
    n_checks++;
    if (n_acc != 5) begin
      n_fail++; $display("FAIL drop_accept: got %0d accepted want 5", n_acc);
    end
    axil_read(32'h0C, rd, rr);
    n_checks++;
    if (rd !== 32'd5) begin
      n_fail++; $display("FAIL drop_cnt: got %0d want 5", rd);
    end
    axil_read(32'h14, rd, rr);
    n_checks++;
    if (rd !== 32'h3) begin
      n_fail++; $display("FAIL irq_status_set: got %h want 00000003", rd);
    end
    axil_read(32'h04, rd, rr);
    n_checks++;
    if (rd !== 32'h0006_0010) begin
      n_fail++; $display("FAIL status_drop_full: got %h want 00060010", rd);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked: got %b want 0", irq);
    end
    axil_write(32'h00, 32'h6, 4'hF, br);
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_enabled: got %b want 1", irq);
    end
    axil_write(32'h14, 32'h3, 4'hF, br);
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_cleared: got %b want 0", irq);
    end
    sout.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0;
      n_checks++;
      if (sout.tvalid !== 1'b1 || {sout.tlast, sout.tdata} !== exp) begin
        n_fail++; $display("FAIL drop_drain_beat%0d: got v=%b %b/%h want v=1 %b/%h", i,
                           sout.tvalid, sout.tlast, sout.tdata, exp[32], exp[31:0]);
      end
      @(posedge clk); #1;
    end
    sout.tready = 1'b0;
    axil_write(32'h00, 32'h0, 4'hF, br);
    axil_write(32'h0C, 32'h1234_5678, 4'h0, br);
    axil_read(32'h0C, rd, rr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL drop_cnt_clear: got %h want 00000000", rd);
    end
  endtask

  task automatic test_aw_w_order();
    // W first, AW two cycles later, B held off for three cycles.
    axil.bready = 1'b0;
    axil.wdata = 32'd12; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    @(posedge clk); #1;
    axil.wvalid = 1'b0;
    n_checks++;
    if (axil.wready !== 1'b0 || axil.awready !== 1'b1 || axil.bvalid !== 1'b0) begin
      n_fail++; $display("FAIL w_held: got wready=%b awready=%b bvalid=%b want 0 1 0",
                         axil.wready, axil.awready, axil.bvalid);
    end
    @(posedge clk); #1;
    axil.awaddr = 32'h08; axil.awvalid = 1'b1;
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (axil.bvalid !== 1'b1 || axil.awready !== 1'b0 || axil.wready !== 1'b0) begin
        n_fail++; $display("FAIL b_hold%0d: got bvalid=%b awready=%b wready=%b want 1 0 0",
                           k, axil.bvalid, axil.awready, axil.wready);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (axil.bvalid !== 1'b1 || axil.bresp !== 2'b00) begin
      n_fail++; $display("FAIL b_resp: got bvalid=%b bresp=%b want 1 00", axil.bvalid, axil.bresp);
    end
    axil.bready = 1'b1;
    @(posedge clk); #1;
    axil.bready = 1'b0;
    n_checks++;
    if (axil.bvalid !== 1'b0 || axil.awready !== 1'b1 || axil.wready !== 1'b1) begin
      n_fail++; $display("FAIL b_done: got bvalid=%b awready=%b wready=%b want 0 1 1",
                         axil.bvalid, axil.awready, axil.wready);
    end
    axil_read(32'h08, rd, rr);
    n_checks++;
    if (rd !== 32'd12) begin
      n_fail++; $display("FAIL thresh_w_first: got %h want 0000000c", rd);
    end
    // AW first, W one cycle later, with a single-byte strobe.
    axil.awaddr = 32'h08; axil.awvalid = 1'b1;
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
    axil.wdata = 32'hABCD_FF03; axil.wstrb = 4'h1; axil.wvalid = 1'b1;
    @(posedge clk); #1;
    axil.wvalid = 1'b0;
    axil.bready = 1'b1;
    n_checks++;
    if (axil.bvalid !== 1'b1) begin
      n_fail++; $display("FAIL b_aw_first: got bvalid=%b want 1", axil.bvalid);
    end
    @(posedge clk); #1;
    axil.bready = 1'b0;
    axil_read(32'h08, rd, rr);
    n_checks++;
    if (rd !== 32'd3) begin
      n_fail++; $display("FAIL thresh_wstrb: got %h want 00000003", rd);
    end
    axil_write(32'h08, 32'd14, 4'h3, br);
  endtask

  task automatic test_flush();
    bit ok, prev_zero, post_seen;
    int zero_cnt;
    logic post_tvalid, post_tready;
    sout.tready = 1'b0;
    for (int i = 0; i < 10; i++) push_beat(32'h300 + i, 1'b0, ok);
    sb_q.delete();
    zero_cnt = 0; prev_zero = 0; post_seen = 0; post_tvalid = 1'bx; post_tready = 1'bx;
    sin.tdata = 32'h3AA; sin.tlast = 1'b0; sin.tvalid = 1'b1; sout.tready = 1'b1;
    fork
      axil_write(32'h00, 32'h1, 4'hF, br);
      begin
        for (int c = 0; c < 30; c++) begin
          #1;
          if (prev_zero && !post_seen) begin
            post_seen = 1; post_tvalid = sout.tvalid; post_tready = sin.tready;
          end
          prev_zero = !sin.tready && !sout.tvalid;
          if (prev_zero) zero_cnt++;
          @(posedge clk);
        end
      end
    join
    @(posedge clk); #1;
    sin.tvalid = 1'b0;
    n_checks++;
    if (zero_cnt != 1) begin
      n_fail++; $display("FAIL flush_pulse_cycles: got %0d want 1", zero_cnt);
    end
    n_checks++;
    if (post_tvalid !== 1'b0 || post_tready !== 1'b1) begin
      n_fail++; $display("FAIL flush_empty_after: got tvalid=%b tready=%b want 0 1",
                         post_tvalid, post_tready);
    end
    repeat (4) @(posedge clk);
    #1;
    sout.tready = 1'b0;
    axil_read(32'h04, rd, rr);
    n_checks++;
    if (rd !== 32'h0001_0000) begin
      n_fail++; $display("FAIL status_after_flush: got %h want 00010000", rd);
    end
    axil_read(32'h00, rd, rr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL ctrl_self_clear: got %h want 00000000", rd);
    end
    axil_read(32'h10, rd, rr);
    n_checks++;
    if (rd !== 32'd2) begin
      n_fail++; $display("FAIL pkt_cnt_kept: got %0d want 2", rd);
    end
  endtask

  task automatic test_reset_mid_write();
    int b_seen;
    axil_write(32'h00, 32'h6, 4'hF, br);
    axil_write(32'h08, 32'd5, 4'hF, br);
    axil.awaddr = 32'h00; axil.awvalid = 1'b1;
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
    axil.wdata = 32'h2; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    rst = 1'b1;
    axil.bready = 1'b1;
    b_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (axil.bvalid) b_seen++;
    end
    axil.wvalid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (axil.bvalid) b_seen++;
    end
    axil.bready = 1'b0;
    n_checks++;
    if (b_seen != 0) begin
      n_fail++; $display("FAIL reset_abort_b: got %0d bvalid cycles want 0", b_seen);
    end
    n_checks++;
    if (axil.awready !== 1'b1 || axil.wready !== 1'b1) begin
      n_fail++; $display("FAIL reset_abort_ready: got awready=%b wready=%b want 1 1",
                         axil.awready, axil.wready);
    end
    axil_read(32'h00, rd, rr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL ctrl_after_reset: got %h want 00000000", rd);
    end
    axil_read(32'h08, rd, rr);
    n_checks++;
    if (rd !== 32'd14) begin
      n_fail++; $display("FAIL thresh_after_reset: got %h want 0000000e", rd);
    end
    axil_read(32'h10, rd, rr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL pkt_after_reset: got %h want 00000000", rd);
    end
    axil_read(32'h14, rd, rr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL irq_status_after_reset: got %h want 00000000", rd);
    end
    axil_read(32'h04, rd, rr);
    n_checks++;
    if (rd !== 32'h0001_0000) begin
      n_fail++; $display("FAIL status_after_reset: got %h want 00010000", rd);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1;
    test_reset();
    test_fill_drain();
    test_drop_irq();
    test_aw_w_order();
    test_flush();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
